call_request_tx: RTL and testbench

//  Transmit side of the controller request interface: queues passenger calls (src, dest) from the hall/cab panel
//  and presents them one at a time to the controller as src_input/dest_input/direction_input with a set_clk strobe.

---
 rtl/elevator_pkg.sv | 30 +++
 rtl/call_fifo.sv | 71 +++++++
 rtl/call_request_tx.sv | 150 +++++++++++++++
 tb/tb_call_request_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator call types: floor code, direction encoding, queued call record, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package elevator_pkg;

    localparam int FLOOR_W = 3;

    typedef logic [FLOOR_W-1:0] floor_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        floor_t src;
        floor_t dest;
        logic   dir;
    } call_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        GAP    = 2'd3
    } tx_state_t;

    function automatic logic call_dir(input floor_t src, input floor_t dest);
        return (dest > src) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/call_fifo.sv
// Synchronous FIFO of call_t; exposes every slot with a live mask for duplicate lookup.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; same-cycle push+pop keeps count.
module call_fifo
    import elevator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  call_t                    push_dat,
    input  logic                     pop,
    output call_t                    head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output call_t [DEPTH-1:0]        entries,
    output logic  [DEPTH-1:0]        entry_vld
);

    localparam int PW = $clog2(DEPTH);

    call_t [DEPTH-1:0] mem;
    logic  [PW-1:0]    wr_ptr;
    logic  [PW-1:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_vld[i] = ((PW+1)'(PW'(i) - rd_ptr) < count);
        end
    end

endmodule

// File: rtl/call_request_tx.sv
// Queues panel calls and presents them one at a time to the controller with a set_clk strobe.
// Latency: accept edge N -> SETUP at N+1 -> set_clk at N+2; strobe period 1+STROBE_CYC+GAP_CYC.
// Backpressure: req_ready = !full; optional DUP_FILTER_EN drops calls already queued or in flight.
module call_request_tx
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int STROBE_CYC = 1,
    parameter int GAP_CYC    = 25
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [FLOOR_W-1:0]            req_src,
    input  logic [FLOOR_W-1:0]            req_dest,
    output logic                          req_err,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic                          set_clk,
    output logic [FLOOR_W-1:0]            src_input,
    output logic [FLOOR_W-1:0]            dest_input,
    output logic                          direction_input,
    output logic                          busy
);

    localparam int     CNT_MAX   = (GAP_CYC > STROBE_CYC) ? GAP_CYC : STROBE_CYC;
    localparam int     CNT_W     = $clog2(CNT_MAX) + 1;
    localparam floor_t MAX_FLOOR = floor_t'(NUM_FLOORS - 1);

    tx_state_t                 state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic                      pop;
    logic                      load;
    logic                      hs;
    logic                      call_ok;
    logic                      dup;
    logic                      push;
    logic                      full;
    logic                      empty;
    call_t                     head;
    call_t                     push_dat;
    call_t [FIFO_DEPTH-1:0]    entries;
    logic  [FIFO_DEPTH-1:0]    entry_vld;
    logic                      unused_dup;

    assign req_ready = !full;
    assign hs        = req_valid && req_ready;
    assign call_ok   = (req_src != req_dest) && (req_src <= MAX_FLOOR) && (req_dest <= MAX_FLOOR);
    assign push      = hs && call_ok && !dup;
    assign push_dat  = '{src: req_src, dest: req_dest, dir: call_dir(req_src, req_dest)};
    assign busy      = (state != IDLE);
    assign set_clk   = (state == STROBE);
    assign unused_dup = ^{entries, entry_vld};

`ifdef DUP_FILTER_EN
    // Output registers hold the in-flight call whenever the FSM is away from IDLE.
    always_comb begin
        dup = busy && (src_input == req_src) && (dest_input == req_dest);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i] && (entries[i].src == req_src) && (entries[i].dest == req_dest)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

    call_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_dat  (push_dat),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (pending),
        .entries   (entries),
        .entry_vld (entry_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            req_err         <= 1'b0;
            src_input       <= '0;
            dest_input      <= '0;
            direction_input <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            req_err <= hs && !(call_ok && !dup);
            if (load) begin
                src_input       <= head.src;
                dest_input      <= head.dest;
                direction_input <= head.dir;
            end
        end
    end

    // The last GAP cycle launches the next SETUP directly so the period has no idle bubble.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                cnt_n   = '0;
                state_n = STROBE;
            end
            STROBE: begin
                if (cnt == CNT_W'(STROBE_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    cnt_n = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        state_n = SETUP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_call_request_tx.sv
// Directed bench for call_request_tx: latency, spacing, rejection, full queue, reset, duplicates.
module tb_call_request_tx;

`ifdef DUP_FILTER_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_src;
    logic [2:0] req_dest;
    logic       req_err;
    logic [2:0] pending;
    logic       set_clk;
    logic [2:0] src_input;
    logic [2:0] dest_input;
    logic       direction_input;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n0;
    logic prev_set = 1'b0;
    int   st_cyc[$];
    logic [2:0] st_src[$];
    logic [2:0] st_dst[$];
    logic       st_dir[$];

    logic [2:0] c_src [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [2:0] c_dst [6] = '{3'd1, 3'd0, 3'd3, 3'd4, 3'd5, 3'd0};

    call_request_tx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_src         (req_src),
        .req_dest        (req_dest),
        .req_err         (req_err),
        .pending         (pending),
        .set_clk         (set_clk),
        .src_input       (src_input),
        .dest_input      (dest_input),
        .direction_input (direction_input),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every rising set_clk with the data it carried.
    always @(negedge clk) begin
        if (set_clk && !prev_set) begin
            st_cyc.push_back(cyc);
            st_src.push_back(src_input);
            st_dst.push_back(dest_input);
            st_dir.push_back(direction_input);
        end
        prev_set = set_clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        tick;
        while (busy && n < budget) begin
            tick;
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_set(input logic val, input int budget, input string tag);
        int n = 0;
        while (set_clk !== val && n < budget) begin
            tick;
            n++;
        end
        chk(tag, {31'd0, set_clk}, {31'd0, val});
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [2:0] d);
        req_valid = v;
        req_src   = s;
        req_dest  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 3'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_set_clk", {31'd0, set_clk}, 0);
        chk("rst_src", {29'd0, src_input}, 0);
        chk("rst_dest", {29'd0, dest_input}, 0);
        chk("rst_dir", {31'd0, direction_input}, 0);
        chk("rst_req_err", {31'd0, req_err}, 0);
        chk("rst_pending", {29'd0, pending}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        rst_n = 1'b1;
        tick;
        tick;

        // 1: single call (4,2), cycle-exact latency and 1-cycle strobe
        drive(1'b1, 3'd4, 3'd2);
        tick;
        drive(1'b0, 3'd0, 3'd0);
        chk("t1_pending_after_push", {29'd0, pending}, 1);
        chk("t1_idle_after_push", {31'd0, busy}, 0);
        chk("t1_no_err", {31'd0, req_err}, 0);
        tick;
        chk("t1_setup_busy", {31'd0, busy}, 1);
        chk("t1_setup_no_strobe", {31'd0, set_clk}, 0);
        chk("t1_src", {29'd0, src_input}, 4);
        chk("t1_dest", {29'd0, dest_input}, 2);
        chk("t1_dir", {31'd0, direction_input}, 0);
        chk("t1_pending_popped", {29'd0, pending}, 0);
        tick;
        chk("t1_strobe_high", {31'd0, set_clk}, 1);
        tick;
        chk("t1_strobe_low", {31'd0, set_clk}, 0);
        chk("t1_gap_busy", {31'd0, busy}, 1);
        wait_idle(40, "t1_idle_timeout");

        // 2: back-to-back calls, strobes 27 cycles apart
        n0 = st_cyc.size();
        drive(1'b1, 3'd4, 3'd2);
        tick;
        drive(1'b1, 3'd5, 3'd3);
        tick;
        drive(1'b0, 3'd0, 3'd0);
        chk("t2_pending_one", {29'd0, pending}, 1);
        wait_idle(100, "t2_idle_timeout");
        chk("t2_strobe_count", st_cyc.size(), n0 + 2);
        if (st_cyc.size() == n0 + 2) begin
            chk("t2_period", st_cyc[n0+1] - st_cyc[n0], 27);
            chk("t2_second_src", {29'd0, st_src[n0+1]}, 5);
            chk("t2_second_dest", {29'd0, st_dst[n0+1]}, 3);
            chk("t2_second_dir", {31'd0, st_dir[n0+1]}, 0);
        end
        chk("t2_pending_zero", {29'd0, pending}, 0);

        // 3: upward call, then malformed calls rejected
        n0 = st_cyc.size();
        drive(1'b1, 3'd2, 3'd5);
        tick;
        drive(1'b0, 3'd0, 3'd0);
        wait_idle(40, "t3_idle_timeout");
        chk("t3_strobe_count", st_cyc.size(), n0 + 1);
        if (st_cyc.size() == n0 + 1) begin
            chk("t3_up_dir", {31'd0, st_dir[n0]}, 1);
            chk("t3_up_src", {29'd0, st_src[n0]}, 2);
        end
        drive(1'b1, 3'd3, 3'd3);
        tick;
        chk("t3_err_same_floor", {31'd0, req_err}, 1);
        chk("t3_pending_same_floor", {29'd0, pending}, 0);
        drive(1'b1, 3'd7, 3'd1);
        tick;
        drive(1'b0, 3'd0, 3'd0);
        chk("t3_err_out_of_range", {31'd0, req_err}, 1);
        chk("t3_pending_out_of_range", {29'd0, pending}, 0);
        tick;
        chk("t3_err_cleared", {31'd0, req_err}, 0);
        repeat (5) tick;
        chk("t3_no_busy", {31'd0, busy}, 0);
        chk("t3_no_extra_strobe", st_cyc.size(), n0 + 1);

        // 4: six calls offered, queue fills after four, five transmitted in order
        n0 = st_cyc.size();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, c_src[i], c_dst[i]);
            if (i == 5) begin
                chk("t4_full_pending", {29'd0, pending}, 4);
                chk("t4_full_ready", {31'd0, req_ready}, 0);
            end
            tick;
        end
        repeat (3) tick;
        chk("t4_still_full", {29'd0, pending}, 4);
        chk("t4_no_err_when_full", {31'd0, req_err}, 0);
        drive(1'b0, 3'd0, 3'd0);
        wait_idle(200, "t4_idle_timeout");
        chk("t4_strobe_count", st_cyc.size(), n0 + 5);
        if (st_cyc.size() == n0 + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t4_order_src%0d", k), {29'd0, st_src[n0+k]}, {29'd0, c_src[k]});
                chk($sformatf("t4_order_dst%0d", k), {29'd0, st_dst[n0+k]}, {29'd0, c_dst[k]});
            end
        end

        // 5: reset while the strobe is high
        n0 = st_cyc.size();
        drive(1'b1, 3'd1, 3'd2);
        tick;
        drive(1'b1, 3'd2, 3'd1);
        tick;
        drive(1'b1, 3'd3, 3'd1);
        tick;
        drive(1'b0, 3'd0, 3'd0);
        wait_set(1'b1, 10, "t5_strobe_seen");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_set_clk_drop", {31'd0, set_clk}, 0);
        chk("t5_pending_clear", {29'd0, pending}, 0);
        chk("t5_busy_clear", {31'd0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) tick;
        chk("t5_no_more_strobes", st_cyc.size(), n0 + 1);
        chk("t5_idle_after", {31'd0, busy}, 0);

        // 6: same call offered twice during its own GAP
        n0 = st_cyc.size();
        drive(1'b1, 3'd1, 3'd4);
        tick;
        drive(1'b0, 3'd0, 3'd0);
        wait_set(1'b1, 10, "t6_strobe_rise");
        tick;
        wait_set(1'b0, 10, "t6_strobe_fall");
        chk("t6_in_gap", {31'd0, busy}, 1);
        drive(1'b1, 3'd1, 3'd4);
        tick;
        chk("t6_err_first", {31'd0, req_err}, DUP ? 1 : 0);
        chk("t6_pending_first", {29'd0, pending}, DUP ? 0 : 1);
        tick;
        drive(1'b0, 3'd0, 3'd0);
        chk("t6_err_second", {31'd0, req_err}, DUP ? 1 : 0);
        chk("t6_pending_second", {29'd0, pending}, DUP ? 0 : 2);
        wait_idle(120, "t6_idle_timeout");
        chk("t6_strobe_count", st_cyc.size(), n0 + (DUP ? 1 : 3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
